// File: rtl/coherent_split_mem_if.sv
// Core-facing bus of coherent_split_mem: IM fetch port, byte-enabled DM port,
// fence request and sync/log status.
interface coherent_split_mem_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int CW     = $clog2(DEPTH) + 1
);
  logic                  i_im_ren;
  logic [ADDR_W-1:0]     i_im_addr;
  logic [DATA_W-1:0]     o_im_rdata;
  logic                  o_im_rvalid;
  logic                  i_dm_ren;
  logic                  i_dm_wen;
  logic [DATA_W/8-1:0]   i_dm_ben;
  logic [ADDR_W-1:0]     i_dm_addr;
  logic [DATA_W-1:0]     i_dm_wdata;
  logic [DATA_W-1:0]     o_dm_rdata;
  logic                  o_dm_rvalid;
  logic                  i_fence_i;
  logic                  o_ready;
  logic                  o_syncing;
  logic                  o_sync_done;
  logic [CW-1:0]         o_log_count;

  modport master (
    output i_im_ren, i_im_addr, i_dm_ren, i_dm_wen, i_dm_ben, i_dm_addr,
           i_dm_wdata, i_fence_i,
    input  o_im_rdata, o_im_rvalid, o_dm_rdata, o_dm_rvalid, o_ready,
           o_syncing, o_sync_done, o_log_count
  );

  modport slave (
    input  i_im_ren, i_im_addr, i_dm_ren, i_dm_wen, i_dm_ben, i_dm_addr,
           i_dm_wdata, i_fence_i,
    output o_im_rdata, o_im_rvalid, o_dm_rdata, o_dm_rvalid, o_ready,
           o_syncing, o_sync_done, o_log_count
  );
endinterface

// File: rtl/coherent_split_mem.sv
// Split IM/DM memory with a dirty-address log; a sync engine copies logged DM
// words into IM on fence.i or when the log fills.
module coherent_split_mem #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 i_rst,
  coherent_split_mem_if.slave  bus
);
  localparam int LW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SYNC, DRAIN} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_idx;
  logic [LW-1:0]       r_head;
  logic [ADDR_W-1:0]   r_last;
  logic [ADDR_W-1:0]   r_log [DEPTH];
  logic [DATA_W-1:0]   r_im  [2**ADDR_W];
  logic [DATA_W-1:0]   r_dm  [2**ADDR_W];
  logic [DATA_W-1:0]   r_im_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_im_rvalid;
  logic                r_dm_rvalid;
  logic                r_ready;
  logic                r_syncing;
  logic                r_sync_done;

  logic                w_accept;
  logic                w_im_acc;
  logic                w_dm_racc;
  logic                w_dm_wacc;
  logic                w_push;
  logic [CW-1:0]       w_count_nxt;
  logic                w_trigger;
  logic                w_sync_rd;
  logic                w_im_we;
  logic [LW-1:0]       w_prev;
  logic [ADDR_W-1:0]   w_dm_raddr;

  assign w_accept    = r_ready && !i_rst;
  assign w_im_acc    = w_accept && bus.i_im_ren;
  assign w_dm_racc   = w_accept && bus.i_dm_ren;
  assign w_dm_wacc   = w_accept && bus.i_dm_wen;
  // Repeated writes to the most recently logged address share one entry.
  assign w_push      = w_dm_wacc && !((r_count != '0) && (bus.i_dm_addr == r_last));
  assign w_count_nxt = r_count + CW'(w_push);
  assign w_trigger   = (w_count_nxt == CW'(DEPTH)) || (bus.i_fence_i && (w_count_nxt != '0));

  assign w_sync_rd   = (r_state == SYNC);
  assign w_prev      = r_idx[LW-1:0] - LW'(1);
  assign w_dm_raddr  = w_sync_rd ? r_log[r_idx[LW-1:0]] : bus.i_dm_addr;
  // IM lags the DM read by one cycle: entry idx-1 lands while idx is fetched.
  assign w_im_we     = (w_sync_rd && (r_idx != '0)) || (r_state == DRAIN);

  always_ff @(posedge clk) begin
    if (w_dm_wacc) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.i_dm_ben[b]) r_dm[bus.i_dm_addr][8*b +: 8] <= bus.i_dm_wdata[8*b +: 8];
      end
    end
    if (w_dm_racc || w_sync_rd) r_dm_rdata <= r_dm[w_dm_raddr];
  end

  always_ff @(posedge clk) begin
    if (w_im_we)  r_im[r_log[w_prev]] <= r_dm_rdata;
    if (w_im_acc) r_im_rdata <= r_im[bus.i_im_addr];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_log[r_head] <= bus.i_dm_addr;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_head      <= '0;
      r_last      <= '0;
      r_im_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_ready     <= 1'b1;
      r_syncing   <= 1'b0;
      r_sync_done <= 1'b0;
    end else begin
      r_im_rvalid <= w_im_acc;
      r_dm_rvalid <= w_dm_racc;
      r_sync_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_head <= r_head + LW'(1);
            r_last <= bus.i_dm_addr;
          end
          r_count <= w_count_nxt;
          if (w_trigger) begin
            r_state   <= SYNC;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_syncing <= 1'b1;
          end else if (bus.i_fence_i) begin
            r_sync_done <= 1'b1;
          end
        end
        SYNC: begin
          r_idx <= r_idx + CW'(1);
          if (r_idx == r_count - CW'(1)) begin
            r_state     <= DRAIN;
            r_sync_done <= 1'b1;
          end
        end
        DRAIN: begin
          r_state   <= IDLE;
          r_count   <= '0;
          r_idx     <= '0;
          r_head    <= '0;
          r_ready   <= 1'b1;
          r_syncing <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_im_rdata  = r_im_rdata;
  assign bus.o_im_rvalid = r_im_rvalid;
  assign bus.o_dm_rdata  = r_dm_rdata;
  assign bus.o_dm_rvalid = r_dm_rvalid;
  assign bus.o_ready     = r_ready;
  assign bus.o_syncing   = r_syncing;
  assign bus.o_sync_done = r_sync_done;
  assign bus.o_log_count = r_count;
endmodule

// File: tb/tb_coherent_split_mem.sv
// Self-checking bench for coherent_split_mem (DEPTH=4) against a queue-based
// reference model of the memories, dirty log and sync stall.
module tb_coherent_split_mem;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coherent_split_mem_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) bus ();
  coherent_split_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .i_rst(rst), .bus(bus)
  );

  // Reference model: word arrays with known-flags, log as a queue of addresses.
  logic [DW-1:0] m_dm [256];
  logic [DW-1:0] m_im [256];
  bit            m_dmv [256];
  bit            m_imv [256];
  int unsigned   q [$];
  bit            m_busy;
  int            m_j, m_n;

  bit            e_ready = 1'b1, e_sync, e_done, e_dmv, e_imv, e_dmk, e_imk;
  int            e_count;
  logic [DW-1:0] e_dmd, e_imd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_idle();
    bus.i_im_ren = 0; bus.i_im_addr = '0; bus.i_dm_ren = 0; bus.i_dm_wen = 0;
    bus.i_dm_ben = '0; bus.i_dm_addr = '0; bus.i_dm_wdata = '0; bus.i_fence_i = 0;
  endtask

  // Advance model by one cycle using the currently driven inputs, then clock.
  task automatic step();
    int unsigned a;
    e_dmv = 0; e_imv = 0; e_done = 0;
    if (rst) begin
      foreach (q[i]) m_imv[q[i]] = 0;
      q.delete(); m_busy = 0;
      e_ready = 1; e_sync = 0; e_count = 0;
    end else if (m_busy) begin
      if (m_j == m_n + 1) begin
        foreach (q[i]) begin m_im[q[i]] = m_dm[q[i]]; m_imv[q[i]] = m_dmv[q[i]]; end
        q.delete(); m_busy = 0;
        e_ready = 1; e_sync = 0; e_count = 0;
      end else begin
        m_j++;
        e_done = (m_j == m_n + 1);
      end
    end else begin
      if (bus.i_im_ren) begin
        a = bus.i_im_addr; e_imv = 1; e_imd = m_im[a]; e_imk = m_imv[a];
      end
      if (bus.i_dm_ren) begin
        a = bus.i_dm_addr; e_dmv = 1; e_dmd = m_dm[a]; e_dmk = m_dmv[a];
      end
      if (bus.i_dm_wen) begin
        a = bus.i_dm_addr;
        for (int b = 0; b < DW/8; b++)
          if (bus.i_dm_ben[b]) m_dm[a][8*b +: 8] = bus.i_dm_wdata[8*b +: 8];
        if (bus.i_dm_ben == '1) m_dmv[a] = 1;
        if (!(q.size() > 0 && q[$] == a)) q.push_back(a);
      end
      e_count = q.size();
      if (q.size() == DEP || (bus.i_fence_i && q.size() > 0)) begin
        m_busy = 1; m_j = 1; m_n = q.size();
        e_ready = 0; e_sync = 1;
      end else if (bus.i_fence_i) begin
        e_done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input int unsigned a, input logic [DW-1:0] d, input logic [3:0] be);
    set_idle(); bus.i_dm_wen = 1; bus.i_dm_addr = AW'(a); bus.i_dm_wdata = d; bus.i_dm_ben = be;
    step(); set_idle();
  endtask

  task automatic rd_dm(input int unsigned a);
    set_idle(); bus.i_dm_ren = 1; bus.i_dm_addr = AW'(a); step(); set_idle();
  endtask

  task automatic rd_im(input int unsigned a);
    set_idle(); bus.i_im_ren = 1; bus.i_im_addr = AW'(a); step(); set_idle();
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; step(); rst = 0;
  endtask

  // Measures stall cycles (o_ready low) and the stall cycle carrying o_sync_done.
  task automatic wait_sync(output int stall, output int done_at);
    stall = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.o_sync_done === 1'b1) done_at = k;
      if (bus.o_ready === 1'b1) break;
      stall++;
      step();
    end
  endtask

  task automatic test_reset();
    set_idle(); rst = 1; step(); rst = 0;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    n_cmp++; if ({bus.o_syncing, bus.o_sync_done, bus.o_im_rvalid, bus.o_dm_rvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.o_syncing, bus.o_sync_done, bus.o_im_rvalid, bus.o_dm_rvalid}); end
    n_cmp++; if (bus.o_log_count !== '0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", bus.o_log_count); end
  endtask

  task automatic test_rw_latency();
    do_reset();
    wr(5, 32'hDEADBEEF, 4'b1111);
    n_cmp++; if (bus.o_dm_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_no_rvalid got=%b exp=0", bus.o_dm_rvalid); end
    n_cmp++; if (bus.o_log_count !== 3'd1) begin n_bad++; $display("FAIL rw_count got=%0d exp=1", bus.o_log_count); end
    rd_dm(5);
    n_cmp++; if (bus.o_dm_rvalid !== 1'b1 || bus.o_dm_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rw_full got=%b/%h exp=1/deadbeef", bus.o_dm_rvalid, bus.o_dm_rdata); end
    wr(5, 32'h0000AA00, 4'b0010);
    rd_dm(5);
    n_cmp++; if (bus.o_dm_rdata !== 32'hDEADAAEF) begin n_bad++; $display("FAIL rw_byte got=%h exp=deadaaef", bus.o_dm_rdata); end
    n_cmp++; if (bus.o_log_count !== 3'd1) begin n_bad++; $display("FAIL rw_dedup got=%0d exp=1", bus.o_log_count); end
  endtask

  task automatic test_fence_sync();
    int stall, done_at;
    do_reset();
    for (int unsigned a = 1; a <= 3; a++) wr(a, 32'h11 * a, 4'hF);
    bus.i_fence_i = 1; step(); set_idle();
    wait_sync(stall, done_at);
    n_cmp++; if (stall != 4) begin n_bad++; $display("FAIL fence_stall got=%0d exp=4", stall); end
    n_cmp++; if (done_at != 4) begin n_bad++; $display("FAIL fence_done_cycle got=%0d exp=4", done_at); end
    n_cmp++; if (bus.o_log_count !== '0) begin n_bad++; $display("FAIL fence_count got=%0d exp=0", bus.o_log_count); end
    for (int unsigned a = 1; a <= 3; a++) begin
      rd_im(a);
      n_cmp++; if (bus.o_im_rvalid !== 1'b1 || bus.o_im_rdata !== 32'h11 * a) begin
        n_bad++; $display("FAIL fence_im%0d got=%b/%h exp=1/%h", a, bus.o_im_rvalid, bus.o_im_rdata, 32'h11 * a); end
    end
  endtask

  task automatic test_dedup_autosync();
    int stall, done_at;
    do_reset();
    wr(7, 32'h70, 4'hF); wr(7, 32'h77, 4'hF); wr(8, 32'h80, 4'hF);
    n_cmp++; if (bus.o_log_count !== 3'd2) begin n_bad++; $display("FAIL dedup_count got=%0d exp=2", bus.o_log_count); end
    wr(9, 32'h90, 4'hF); wr(10, 32'hA0A0, 4'hF);
    n_cmp++; if (bus.o_ready !== 1'b0 || bus.o_syncing !== 1'b1 || bus.o_log_count !== 3'd4) begin
      n_bad++; $display("FAIL auto_start got=r%b/s%b/c%0d exp=r0/s1/c4", bus.o_ready, bus.o_syncing, bus.o_log_count); end
    wait_sync(stall, done_at);
    n_cmp++; if (stall != 5 || done_at != 5) begin n_bad++; $display("FAIL auto_stall got=%0d/%0d exp=5/5", stall, done_at); end
    rd_im(10);
    n_cmp++; if (bus.o_im_rdata !== 32'hA0A0) begin n_bad++; $display("FAIL auto_im10 got=%h exp=0000a0a0", bus.o_im_rdata); end
    rd_im(7);
    n_cmp++; if (bus.o_im_rdata !== 32'h77) begin n_bad++; $display("FAIL auto_im7 got=%h exp=00000077", bus.o_im_rdata); end
  endtask

  task automatic test_fence_empty();
    do_reset();
    bus.i_fence_i = 1; step(); set_idle();
    n_cmp++; if (bus.o_ready !== 1'b1 || bus.o_sync_done !== 1'b1 || bus.o_syncing !== 1'b0) begin
      n_bad++; $display("FAIL empty_fence got=r%b/d%b/s%b exp=r1/d1/s0", bus.o_ready, bus.o_sync_done, bus.o_syncing); end
    step();
    n_cmp++; if (bus.o_sync_done !== 1'b0) begin n_bad++; $display("FAIL empty_pulse got=%b exp=0", bus.o_sync_done); end
  endtask

  task automatic test_fence_with_write();
    int stall, done_at;
    do_reset();
    bus.i_dm_wen = 1; bus.i_dm_addr = 8'd4; bus.i_dm_wdata = 32'h4444_0004; bus.i_dm_ben = 4'hF;
    bus.i_fence_i = 1; step(); set_idle();
    wait_sync(stall, done_at);
    n_cmp++; if (stall != 2 || done_at != 2) begin n_bad++; $display("FAIL fw_stall got=%0d/%0d exp=2/2", stall, done_at); end
    rd_im(4);
    n_cmp++; if (bus.o_im_rdata !== 32'h4444_0004) begin n_bad++; $display("FAIL fw_im4 got=%h exp=44440004", bus.o_im_rdata); end
  endtask

  task automatic test_ignored();
    int stall, done_at;
    do_reset(); wr(20, 32'h2020_2020, 4'hF); do_reset();
    wr(30, 32'h30, 4'hF); wr(31, 32'h31, 4'hF);
    bus.i_fence_i = 1; step(); set_idle();
    bus.i_im_ren = 1; bus.i_im_addr = 8'd20; bus.i_dm_ren = 1; bus.i_dm_wen = 1;
    bus.i_dm_addr = 8'd20; bus.i_dm_wdata = 32'hBAD0_BAD0; bus.i_dm_ben = 4'hF;
    step(); set_idle();
    n_cmp++; if (bus.o_im_rvalid !== 1'b0 || bus.o_dm_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL ign_rvalid got=%b%b exp=00", bus.o_im_rvalid, bus.o_dm_rvalid); end
    n_cmp++; if (bus.o_log_count !== 3'd2) begin n_bad++; $display("FAIL ign_count got=%0d exp=2", bus.o_log_count); end
    wait_sync(stall, done_at);
    n_cmp++; if (stall != 2 || done_at != 2) begin n_bad++; $display("FAIL ign_stall got=%0d/%0d exp=2/2", stall, done_at); end
    rd_dm(20);
    n_cmp++; if (bus.o_dm_rdata !== 32'h2020_2020) begin n_bad++; $display("FAIL ign_dm20 got=%h exp=20202020", bus.o_dm_rdata); end
  endtask

  task automatic test_reset_mid_sync();
    do_reset();
    wr(40, 32'h40, 4'hF); wr(41, 32'h41, 4'hF);
    bus.i_fence_i = 1; step(); set_idle();
    step();
    rst = 1; step(); rst = 0;
    n_cmp++; if (bus.o_ready !== 1'b1 || bus.o_syncing !== 1'b0 || bus.o_sync_done !== 1'b0 || bus.o_log_count !== '0) begin
      n_bad++; $display("FAIL rstmid got=r%b/s%b/d%b/c%0d exp=r1/s0/d0/c0", bus.o_ready, bus.o_syncing, bus.o_sync_done, bus.o_log_count); end
    bus.i_fence_i = 1; step(); set_idle();
    n_cmp++; if (bus.o_ready !== 1'b1 || bus.o_syncing !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_fence got=r%b/s%b exp=r1/s0", bus.o_ready, bus.o_syncing); end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned a = 0; a < 8; a++) begin
      for (int k = 0; k < 20 && m_busy; k++) step();
      wr(a, $urandom, 4'hF);
    end
    for (int c = 0; c < 300; c++) begin
      set_idle();
      bus.i_im_ren   = ($urandom_range(0, 1) == 1);
      bus.i_im_addr  = AW'($urandom_range(0, 7));
      bus.i_dm_ren   = ($urandom_range(0, 1) == 1);
      bus.i_dm_wen   = ($urandom_range(0, 2) == 0);
      bus.i_dm_addr  = AW'($urandom_range(0, 7));
      bus.i_dm_wdata = $urandom;
      bus.i_dm_ben   = 4'($urandom);
      bus.i_fence_i  = ($urandom_range(0, 15) == 0);
      step();
      n_cmp++; if (bus.o_ready !== e_ready || bus.o_syncing !== e_sync || bus.o_sync_done !== e_done) begin
        n_bad++; $display("FAIL rnd_ctl c=%0d got=r%b/s%b/d%b exp=r%b/s%b/d%b", c, bus.o_ready, bus.o_syncing, bus.o_sync_done, e_ready, e_sync, e_done); end
      n_cmp++; if (bus.o_log_count !== 3'(e_count)) begin
        n_bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.o_log_count, e_count); end
      n_cmp++; if (bus.o_im_rvalid !== e_imv || bus.o_dm_rvalid !== e_dmv) begin
        n_bad++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, bus.o_im_rvalid, bus.o_dm_rvalid, e_imv, e_dmv); end
      if (e_dmv && e_dmk) begin
        n_cmp++; if (bus.o_dm_rdata !== e_dmd) begin n_bad++; $display("FAIL rnd_dm c=%0d got=%h exp=%h", c, bus.o_dm_rdata, e_dmd); end
      end
      if (e_imv && e_imk) begin
        n_cmp++; if (bus.o_im_rdata !== e_imd) begin n_bad++; $display("FAIL rnd_im c=%0d got=%h exp=%h", c, bus.o_im_rdata, e_imd); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    test_reset();
    test_rw_latency();
    test_fence_sync();
    test_dedup_autosync();
    test_fence_empty();
    test_fence_with_write();
    test_ignored();
    test_reset_mid_sync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coherent_split_mem.md
# coherent_split_mem

Parametrised split instruction/data memory with a hardware write-back log, giving the core a single-cycle IM fetch port and a byte-enabled DM port. Every DM write address is recorded in a dirty log. On `fence.i`, or when the log fills, a sync engine copies each logged word from DM to IM, one word per cycle. It sits between the core pipeline and on-chip RAM and replaces the fixed-size memory wrapper with a generalised, handshaked version that has a defined completion signal.

## Interface
Parameters:
- ADDR_W, 14, word-address width of each memory (2^ADDR_W words each)
- DATA_W, 32, data width; must be a multiple of 8
- DEPTH, 256, dirty-log entries; must be a power of 2, ≥2
- CW, $clog2(DEPTH)+1, log-count width (derived)

Ports:
- clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_im_ren  in  1  IM read request; accepted only when o_ready=1
- i_im_addr  in  ADDR_W  IM word address
- o_im_rdata  out  DATA_W  IM read data
- o_im_rvalid  out  1  o_im_rdata is valid this cycle
- i_dm_ren  in  1  DM read request; accepted only when o_ready=1
- i_dm_wen  in  1  DM write request; accepted only when o_ready=1
- i_dm_ben  in  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k]
- i_dm_addr  in  ADDR_W  DM word address
- i_dm_wdata  in  DATA_W  DM write data
- o_dm_rdata  out  DATA_W  DM read data
- o_dm_rvalid  out  1  o_dm_rdata is valid this cycle
- i_fence_i  in  1  start a sync; sampled only in IDLE
- o_ready  out  1  core requests accepted this cycle
- o_syncing  out  1  sync engine active
- o_sync_done  out  1  one-cycle pulse when a sync completes
- o_log_count  out  CW  number of valid dirty-log entries

## Operation
- **Memories:** IM and DM are behavioural synchronous arrays. Contents are not reset. If a read and a write hit the same address in the same cycle, the read returns the old data.
- **States:** IDLE, SYNC, DRAIN.
- **o_ready:** high iff state=IDLE and o_log_count<DEPTH.
- **Accepted DM write:**
  - Updates only the enabled bytes.
  - Appends i_dm_addr at log[head] and increments head and count.
  - Dedup: if count>0 and i_dm_addr equals the last appended address, no entry is appended.
- **Ignored requests:** any request while o_ready=0 is ignored; no rvalid, no write, no log change.
- **IDLE → SYNC:** on i_fence_i=1 with count>0, or on count=DEPTH (automatic).
  - A write and i_fence_i in the same accepted cycle: the write is logged first, and its entry is included in the sync.
- **Fence with empty log:** i_fence_i with count=0 (and no write that cycle) causes no state change; o_sync_done pulses the next cycle.
- **SYNC:** index idx starts at 0. Each cycle:
  - DM is read at log[idx].
  - If idx>0, IM[log[idx-1]] is written with the DM data returned from the previous cycle.
  - idx increments each cycle. When idx=count-1 has been read, the next state is DRAIN.
- **DRAIN:** writes the final IM word; head, count and idx are cleared; o_sync_done=1; next state is IDLE.
- **Core ports during sync:** the IM and DM ports are owned by the sync engine; o_im_rvalid=o_dm_rvalid=0 for data belonging to the core.
- **Reset:** state=IDLE, head=idx=count=0, all outputs 0 except o_ready=1.
  - Reset during SYNC or DRAIN abandons the sync; IM may be partially updated.

## Timing
- Read accepted at cycle T → rdata and rvalid at T+1. Back-to-back reads give one result per cycle.
- Write accepted at T → memory and log updated at edge T+1. A read of the same address issued at T+1 returns the new data.
- Sync of N entries, triggered at T:
  - SYNC during T+1..T+N, DRAIN at T+N+1.
  - o_sync_done=1 and o_syncing=1 at T+N+1; o_ready=1 at T+N+2.
  - Total stall is N+1 cycles.
- o_syncing=1 in SYNC and DRAIN.
- Auto-sync: the write that makes count=DEPTH is accepted at T; o_ready=0 from T+1; SYNC starts at T+1.
- o_log_count is registered and updates on the edge following an accepted write.

## Test plan
- **Read/write latency:** DM write addr 5, data 0xDEADBEEF, ben 4'b1111, then DM read addr 5 → o_dm_rdata=0xDEADBEEF with o_dm_rvalid one cycle after the read request. Then write ben 4'b0010, data 0x0000AA00 → read returns 0xDEADAAEF.
- **Fence sync:** DEPTH=4. Write DM 1=0x11, 2=0x22, 3=0x33; fence at T.
  - o_ready low during T+1..T+4; o_sync_done at T+4; o_log_count=0.
  - IM reads of 1, 2, 3 then return 0x11, 0x22, 0x33.
- **Dedup and auto-sync:** DEPTH=4. Writes to addresses 7, 7, 8 → o_log_count=2. Writes to 9, 10 → count=4, o_ready drops the next cycle, auto-sync runs 4+1 cycles with no fence, IM[10] updated.
- **Empty fence and fence-with-write:**
  - Fence with count=0 → o_ready stays 1; o_sync_done pulses next cycle.
  - Write addr 4 plus fence in the same cycle → sync of 1 entry; IM[4] updated; 2-cycle stall.
- **Ignored requests:** IM/DM reads and a DM write to addr 20 issued during SYNC → no rvalid, DM[20] unchanged, log unchanged.
- **Reset mid-sync:** i_rst during SYNC → next cycle o_ready=1, o_syncing=0, o_log_count=0, no o_sync_done; a subsequent fence causes no sync.
